// File: rtl/ecpu_bus_pkg.sv
// Shared definitions for the CPU internal data bus blocks.
package ecpu_bus_pkg;

  localparam int unsigned DATA_BUS_SIZE_DEF = 16;
  localparam int unsigned KEY_SIZE_DEF      = 8;

  // Output-register occupancy for the keyed mux handshake.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Ceiling log2; returns 0 for inputs 0 and 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/key_match_encoder.sv
// Combinational priority equality encoder: compares a key against one
// compile-time code per channel and reports the lowest matching index.
module key_match_encoder
  import ecpu_bus_pkg::*;
#(
  parameter int unsigned KEY_SIZE = KEY_SIZE_DEF,
  parameter int unsigned CHANNELS = 4,
  parameter logic [CHANNELS*KEY_SIZE-1:0] CODES = 32'h03020100,
  parameter int unsigned IDX_W = (CHANNELS > 1) ? clog2(CHANNELS) : 1
) (
  input  logic [KEY_SIZE-1:0] key,
  output logic                any_match,
  output logic [IDX_W-1:0]    index
);

  // Scan from the top channel down so the lowest matching index is the last
  // assignment and therefore wins, which also resolves duplicate codes.
  always_comb begin
    any_match = 1'b0;
    index     = '0;
    for (int unsigned i = CHANNELS; i > 0; i--) begin
      if (key == CODES[(i-1)*KEY_SIZE +: KEY_SIZE]) begin
        any_match = 1'b1;
        index     = IDX_W'(i - 1);
      end
    end
  end

endmodule

// File: rtl/keyed_bus_mux.sv
// Registered N-channel keyed bus multiplexer with ready/valid output,
// sticky overrun flag and saturating miss counter.
module keyed_bus_mux
  import ecpu_bus_pkg::*;
#(
  parameter int unsigned DATA_BUS_SIZE = DATA_BUS_SIZE_DEF,
  parameter int unsigned KEY_SIZE      = KEY_SIZE_DEF,
  parameter int unsigned CHANNELS      = 4,
  parameter logic [CHANNELS*KEY_SIZE-1:0] CODES = 32'h03020100,
  parameter int unsigned IDX_W         = (CHANNELS > 1) ? clog2(CHANNELS) : 1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CHANNELS*DATA_BUS_SIZE-1:0] data_in,
  input  logic [DATA_BUS_SIZE-1:0]          pass,
  input  logic [KEY_SIZE-1:0]               key,
  input  logic                              key_valid,
  output logic                              key_ready,
  output logic [DATA_BUS_SIZE-1:0]          data_out,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              hit,
  output logic [IDX_W-1:0]                  hit_index,
  output logic                              overrun,
  output logic [CNT_W-1:0]                  miss_count
);

  state_t                   state;
  logic                     any_match;
  logic [IDX_W-1:0]         win_idx;
  logic [DATA_BUS_SIZE-1:0] sel_word;
  logic                     capture;
  logic                     transfer;

  key_match_encoder #(
    .KEY_SIZE (KEY_SIZE),
    .CHANNELS (CHANNELS),
    .CODES    (CODES),
    .IDX_W    (IDX_W)
  ) u_enc (
    .key       (key),
    .any_match (any_match),
    .index     (win_idx)
  );

  // Handshake decode; key_ready has no path from key_valid.
  always_comb begin
    out_valid = (state == ST_FULL);
    key_ready = (state == ST_EMPTY) | out_ready;
    capture   = key_valid & key_ready;
    transfer  = out_valid & out_ready;
  end

  // Pick the winning channel word, or the pass word on a miss.
  always_comb begin
    sel_word = pass;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (any_match && (win_idx == IDX_W'(i))) begin
        sel_word = data_in[i*DATA_BUS_SIZE +: DATA_BUS_SIZE];
      end
    end
  end

  // Occupancy FSM, output registers, overrun flag and miss counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EMPTY;
      data_out   <= '0;
      hit        <= 1'b0;
      hit_index  <= '0;
      overrun    <= 1'b0;
      miss_count <= '0;
    end else begin
      if (capture) begin
        state     <= ST_FULL;
        data_out  <= sel_word;
        hit       <= any_match;
        hit_index <= any_match ? win_idx : '0;
        if (!any_match && (miss_count != '1)) begin
          miss_count <= miss_count + 1'b1;
        end
      end else if (transfer) begin
        state <= ST_EMPTY;
      end
      if (key_valid && !key_ready) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_keyed_bus_mux.sv
// Directed self-checking bench for keyed_bus_mux.
module tb_keyed_bus_mux;

  localparam int unsigned DW = 16;
  localparam int unsigned KW = 8;
  localparam int unsigned CH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rst_b;
  logic [CH*DW-1:0] data_in;
  logic [DW-1:0] pass;
  logic [KW-1:0] key;
  logic          key_valid;
  logic          out_ready;

  logic          key_ready, out_valid, hit, overrun;
  logic [DW-1:0] data_out;
  logic [1:0]    hit_index;
  logic [7:0]    miss_count;

  logic          key_ready_b, out_valid_b, hit_b, overrun_b;
  logic [DW-1:0] data_out_b;
  logic [1:0]    hit_index_b;
  logic [7:0]    miss_count_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keyed_bus_mux #(
    .DATA_BUS_SIZE (DW),
    .KEY_SIZE      (KW),
    .CHANNELS      (CH),
    .CODES         (32'h03020100),
    .IDX_W         (2),
    .CNT_W         (8)
  ) dut (
    .clk (clk), .rst (rst), .data_in (data_in), .pass (pass), .key (key),
    .key_valid (key_valid), .key_ready (key_ready), .data_out (data_out),
    .out_valid (out_valid), .out_ready (out_ready), .hit (hit),
    .hit_index (hit_index), .overrun (overrun), .miss_count (miss_count)
  );

  keyed_bus_mux #(
    .DATA_BUS_SIZE (DW),
    .KEY_SIZE      (KW),
    .CHANNELS      (CH),
    .CODES         (32'h05050505),
    .IDX_W         (2),
    .CNT_W         (8)
  ) dut_dup (
    .clk (clk), .rst (rst_b), .data_in (data_in), .pass (pass), .key (key),
    .key_valid (key_valid), .key_ready (key_ready_b), .data_out (data_out_b),
    .out_valid (out_valid_b), .out_ready (out_ready), .hit (hit_b),
    .hit_index (hit_index_b), .overrun (overrun_b), .miss_count (miss_count_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rst_b = 1'b1;
    data_in = '0; pass = '0; key = '0; key_valid = 1'b0; out_ready = 1'b0;

    // Reset then idle
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_data_out", data_out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_key_ready", key_ready, 1);
    chk("rst_overrun", overrun, 0);
    chk("rst_miss_count", miss_count, 0);
    chk("rst_hit", hit, 0);
    chk("rst_hit_index", hit_index, 0);

    // Single hit on channel 2 with back-pressure
    data_in = {16'hA333, 16'hBEEF, 16'hA111, 16'hA000};
    key = 8'h02; key_valid = 1'b1; out_ready = 1'b0;
    tick();
    key_valid = 1'b0; key = 8'h00;
    chk("hit_data_out", data_out, 16'hBEEF);
    chk("hit_hit", hit, 1);
    chk("hit_index", hit_index, 2);
    chk("hit_out_valid", out_valid, 1);
    chk("hit_key_ready_full", key_ready, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_data_out", data_out, 16'hBEEF);
      chk("hold_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    chk("key_ready_follows_out_ready", key_ready, 1);
    tick();
    chk("xfer_out_valid", out_valid, 0);
    chk("xfer_data_kept", data_out, 16'hBEEF);
    chk("xfer_hit_kept", hit, 1);

    // Miss stream and counter saturation
    key = 8'h7F; pass = 16'h1234; key_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 0)   chk("miss_cnt_1", miss_count, 1);
      if (i == 253) chk("miss_cnt_254", miss_count, 254);
      if (i == 254) chk("miss_cnt_255", miss_count, 255);
    end
    chk("miss_data_out", data_out, 16'h1234);
    chk("miss_hit", hit, 0);
    chk("miss_hit_index", hit_index, 0);
    chk("miss_cnt_sat", miss_count, 255);
    chk("miss_out_valid", out_valid, 1);
    chk("miss_no_overrun", overrun, 0);
    key_valid = 1'b0;
    tick();
    chk("miss_drain", out_valid, 0);
    chk("miss_cnt_hold", miss_count, 255);

    // Back-to-back captures at full throughput
    key = 8'h00; key_valid = 1'b1;
    tick();
    chk("b2b_ch0", data_out, 16'hA000);
    chk("b2b_v0", out_valid, 1);
    key = 8'h01;
    tick();
    chk("b2b_ch1", data_out, 16'hA111);
    chk("b2b_v1", out_valid, 1);
    key = 8'h03;
    tick();
    chk("b2b_ch3", data_out, 16'hA333);
    chk("b2b_idx3", hit_index, 3);
    chk("b2b_v3", out_valid, 1);
    key_valid = 1'b0;
    tick();
    chk("b2b_drain", out_valid, 0);
    chk("b2b_no_overrun", overrun, 0);
    chk("b2b_cnt", miss_count, 255);

    // Overrun: strobe while full and not accepted
    out_ready = 1'b0; key = 8'h01; key_valid = 1'b1;
    tick();
    chk("ovr_capture", data_out, 16'hA111);
    key = 8'h03;
    #1;
    chk("ovr_key_ready", key_ready, 0);
    tick();
    key_valid = 1'b0;
    chk("ovr_data_kept", data_out, 16'hA111);
    chk("ovr_idx_kept", hit_index, 1);
    chk("ovr_flag", overrun, 1);
    chk("ovr_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    chk("ovr_xfer", out_valid, 0);
    chk("ovr_sticky1", overrun, 1);
    tick();
    chk("ovr_sticky2", overrun, 1);

    // Duplicate codes: lowest index wins; then reset mid-hold
    rst_b = 1'b0; out_ready = 1'b0;
    key = 8'h05; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    chk("dup_hit", hit_b, 1);
    chk("dup_index", hit_index_b, 0);
    chk("dup_data", data_out_b, 16'hA000);
    chk("dup_valid", out_valid_b, 1);
    rst_b = 1'b1;
    tick();
    chk("midrst_valid", out_valid_b, 0);
    chk("midrst_data", data_out_b, 0);
    chk("midrst_hit", hit_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
